// File: rtl/matrix_frame_buffer_if.sv
// +--------------------------------------------------------------------------+
// | matrix_frame_buffer_if : producer/scanner bus for the LED frame buffer   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface matrix_frame_buffer_if #(
  parameter int COLUMNS = 5,
  parameter int ROWS    = 7,
  parameter int COL_W   = 3
);
  logic               write_valid;
  logic               write_ready;
  logic [COL_W-1:0]   write_column;
  logic [ROWS-1:0]    write_rows;
  logic               write_error;
  logic               commit;
  logic               commit_pending;
  logic [COLUMNS-1:0] scan_column;
  logic               scan_advance;
  logic [ROWS-1:0]    display_rows;
  logic               frame_swapped;

  modport master (
    output write_valid, write_column, write_rows, commit, scan_column, scan_advance,
    input  write_ready, write_error, commit_pending, display_rows, frame_swapped
  );

  modport slave (
    input  write_valid, write_column, write_rows, commit, scan_column, scan_advance,
    output write_ready, write_error, commit_pending, display_rows, frame_swapped
  );
endinterface

`default_nettype wire

// File: rtl/matrix_frame_buffer.sv
// +--------------------------------------------------------------------------+
// | matrix_frame_buffer : double-buffered 5x7 image store, frame-synced swap |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module matrix_frame_buffer #(
  parameter int COLUMNS = 5,
  parameter int ROWS    = 7,
  parameter int COL_W   = 3
) (
  input  wire logic             clock,
  input  wire logic             reset_n,
  matrix_frame_buffer_if.slave  bus
);

  localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(COLUMNS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_COPY    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ROWS-1:0]    r_bank [2][COLUMNS];
  logic               r_front_sel;
  logic [COL_W-1:0]   r_copy_idx;
  logic               r_write_error;
  logic [ROWS-1:0]    r_display;

  logic               w_write_ready;
  logic               w_swap;
  logic               w_write_fire;
  logic               w_col_ok;
  logic               w_back_sel;
  logic [ROWS-1:0]    w_read_rows;
  logic               w_hit;
  logic               w_multi;

  assign w_back_sel   = ~r_front_sel;
  assign w_write_fire = bus.write_valid && w_write_ready;
  assign w_col_ok     = (bus.write_column <= c_LAST_COL);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_write_ready = 1'b0;
    w_swap        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_write_ready = 1'b1;
        if (bus.commit) begin
          w_state_next = S_PENDING;
        end
      end
      S_PENDING: begin
        // Swap only as the scanner wraps from the last column back to column 0.
        if (bus.scan_advance && bus.scan_column[COLUMNS-1]) begin
          w_swap       = 1'b1;
          w_state_next = S_COPY;
        end
      end
      S_COPY: begin
        if (r_copy_idx == c_LAST_COL) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Only an exactly one-hot scan selects a column; anything else blanks.
  always_comb begin
    w_read_rows = '0;
    w_hit       = 1'b0;
    w_multi     = 1'b0;
    for (int c = 0; c < COLUMNS; c++) begin
      if (bus.scan_column[c]) begin
        w_multi     = w_multi | w_hit;
        w_hit       = 1'b1;
        w_read_rows = r_bank[r_front_sel][c];
      end
    end
    if (w_multi) begin
      w_read_rows = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int c = 0; c < COLUMNS; c++) begin
        r_bank[0][c] <= '0;
        r_bank[1][c] <= '0;
      end
      r_front_sel   <= 1'b0;
      r_copy_idx    <= '0;
      r_write_error <= 1'b0;
      r_display     <= '0;
    end else begin
      r_write_error <= w_write_fire && !w_col_ok;
      r_display     <= w_read_rows;
      if (w_write_fire && w_col_ok) begin
        r_bank[w_back_sel][bus.write_column] <= bus.write_rows;
      end
      if (w_swap) begin
        r_front_sel <= ~r_front_sel;
        r_copy_idx  <= '0;
      end
      // Refresh the back bank from the new front so edits can be incremental.
      if (r_state == S_COPY) begin
        r_bank[w_back_sel][r_copy_idx] <= r_bank[r_front_sel][r_copy_idx];
        r_copy_idx                     <= r_copy_idx + 1'b1;
      end
    end
  end

  assign bus.write_ready    = w_write_ready;
  assign bus.write_error    = r_write_error;
  assign bus.commit_pending = (r_state != S_IDLE);
  assign bus.display_rows   = r_display;
  assign bus.frame_swapped  = w_swap;

endmodule

`default_nettype wire

// File: tb/tb_matrix_frame_buffer.sv
// +--------------------------------------------------------------------------+
// | tb_matrix_frame_buffer : directed + random bench with image-level model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_matrix_frame_buffer;
  localparam int COLUMNS = 5;
  localparam int ROWS    = 7;
  localparam int COL_W   = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  matrix_frame_buffer_if #(.COLUMNS(COLUMNS), .ROWS(ROWS), .COL_W(COL_W)) bus ();

  matrix_frame_buffer #(.COLUMNS(COLUMNS), .ROWS(ROWS), .COL_W(COL_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  // Image-level model: the two pictures, whether a commit waits, copy time left.
  logic [ROWS-1:0] m_front [COLUMNS];
  logic [ROWS-1:0] m_back  [COLUMNS];
  bit              m_pending;
  int              m_copy_left;
  logic [ROWS-1:0] m_disp;
  bit              m_err;

  bit auto_scan = 1'b1;
  int sc_pos = 0;
  int adv_period = 2;
  int adv_ctr = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < COLUMNS; c++) begin
      m_front[c] = '0;
      m_back[c]  = '0;
    end
    m_pending   = 1'b0;
    m_copy_left = 0;
    m_disp      = '0;
    m_err       = 1'b0;
  endtask

  task automatic step();
    bit ready;
    bit swap;
    bit fire;
    bit adv_was;
    #3;
    ready = !m_pending && (m_copy_left == 0);
    swap  = m_pending && bus.scan_advance && bus.scan_column[COLUMNS-1];
    check("write_ready", 32'(bus.write_ready), 32'(ready));
    check("commit_pending", 32'(bus.commit_pending), 32'(m_pending || (m_copy_left > 0)));
    check("frame_swapped", 32'(bus.frame_swapped), 32'(swap));
    check("write_error", 32'(bus.write_error), 32'(m_err));
    check("display_rows", 32'(bus.display_rows), 32'(m_disp));
    adv_was = bus.scan_advance;
    if (!reset_n) begin
      model_reset();
    end else begin
      fire  = bus.write_valid && ready;
      m_err = fire && (int'(bus.write_column) >= COLUMNS);
      if ($countones(bus.scan_column) == 1) m_disp = m_front[$clog2(bus.scan_column)];
      else m_disp = '0;
      if (fire && int'(bus.write_column) < COLUMNS) m_back[bus.write_column] = bus.write_rows;
      if (m_copy_left > 0) m_copy_left--;
      if (swap) begin
        m_front     = m_back;
        m_back      = m_front;
        m_pending   = 1'b0;
        m_copy_left = COLUMNS;
      end else if (ready && bus.commit) begin
        m_pending = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    if (auto_scan) begin
      if (adv_was) sc_pos = (sc_pos + 1) % COLUMNS;
      adv_ctr++;
      bus.scan_column  = COLUMNS'(1) << sc_pos;
      bus.scan_advance = (adv_ctr % adv_period == 0);
    end
  endtask

  task automatic do_write(int col, logic [ROWS-1:0] rows, bit cmt);
    bus.write_valid  = 1'b1;
    bus.write_column = COL_W'(col);
    bus.write_rows   = rows;
    bus.commit       = cmt;
    step();
    bus.write_valid  = 1'b0;
    bus.commit       = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while ((m_pending || m_copy_left > 0) && n < budget) begin
      step();
      n++;
    end
    tests++;
    assert (n < budget) else begin
      fails++;
      $error("FAIL wait_idle observed=%0d expected<%0d", n, budget);
    end
  endtask

  initial begin
    int n;
    bus.write_valid  = 1'b0;
    bus.write_column = '0;
    bus.write_rows   = '0;
    bus.commit       = 1'b0;
    bus.scan_column  = 5'b00001;
    bus.scan_advance = 1'b0;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    step();
    reset_n = 1'b1;

    // Blank image on every column after reset.
    for (int k = 0; k < 2 * COLUMNS + 2; k++) step();

    // Walking-bit image committed while the scanner sits mid-frame.
    sc_pos = 2;
    adv_period = 3;
    do_write(0, 7'h01, 1'b0);
    do_write(1, 7'h02, 1'b0);
    do_write(2, 7'h04, 1'b0);
    do_write(3, 7'h08, 1'b0);
    do_write(4, 7'h10, 1'b1);
    wait_idle(100);
    for (int k = 0; k < 16; k++) step();

    // Single-column edit relies on the copy-back for the other columns.
    do_write(2, 7'h7F, 1'b1);
    wait_idle(100);
    for (int k = 0; k < 16; k++) step();

    // Write held through PENDING/COPY; commit held during COPY must not re-arm.
    bus.commit = 1'b1;
    step();
    bus.commit       = 1'b0;
    bus.write_valid  = 1'b1;
    bus.write_column = 3'd3;
    bus.write_rows   = 7'h55;
    n = 0;
    while ((m_pending || m_copy_left > 0) && n < 100) begin
      bus.commit = (m_copy_left >= 2);
      step();
      n++;
    end
    bus.commit = 1'b0;
    step();
    bus.write_valid = 1'b0;
    for (int k = 0; k < 20; k++) step();
    do_write(1, 7'h33, 1'b1);
    wait_idle(100);
    for (int k = 0; k < 16; k++) step();

    // Out-of-range columns and illegal scan patterns.
    do_write(5, 7'h7F, 1'b0);
    do_write(7, 7'h2A, 1'b0);
    step();
    auto_scan = 1'b0;
    bus.scan_advance = 1'b0;
    bus.scan_column = 5'b00011; step(); step();
    bus.scan_column = 5'b00000; step(); step();
    bus.scan_column = 5'b01000; step(); step();
    auto_scan = 1'b1;

    // Reset in the middle of the copy phase.
    do_write(0, 7'h6B, 1'b1);
    n = 0;
    while (m_copy_left != 3 && n < 100) begin
      step();
      n++;
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) step();

    // Random images, edits and commits under varying scan rates.
    for (int r = 0; r < 16; r++) begin
      adv_period = $urandom_range(1, 3);
      for (int w = 0; w < 6; w++) begin
        bus.write_valid  = 1'($urandom_range(0, 1));
        bus.write_column = COL_W'($urandom_range(0, 7));
        bus.write_rows   = ROWS'($urandom);
        bus.commit       = (w == 5) ? 1'b1 : 1'($urandom_range(0, 7) == 0);
        step();
      end
      bus.write_valid = 1'b0;
      bus.commit      = 1'b0;
      wait_idle(120);
      for (int k = 0; k < int'($urandom_range(0, 8)); k++) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matrix_frame_buffer.md
Name: matrix_frame_buffer

Overview:
- Double-buffered image store for the 5x7 LED matrix; it is the write side feeding the column scanner.
- The image producer writes column patterns into a back bank, then requests a commit.
- The block swaps banks only at a scan-frame boundary, so a half-drawn image is never displayed.
- It returns the 7 row bits for whichever column the scanner currently selects.

Parameters:
COLUMNS, 5, number of matrix columns (one-hot scan width)
ROWS, 7, number of matrix rows (bits per column pattern)
COL_W, 3, width of write column index; must satisfy 2^COL_W >= COLUMNS

Ports:
clock  input  1  system clock; fast-clock domain; scan strobes are enables, not clocks
reset_n  input  1  synchronous, active-low reset
write_valid  input  1  producer presents a column write
write_ready  output  1  block can accept a write this cycle
write_column  input  COL_W  target column index, 0..COLUMNS-1
write_rows  input  ROWS  row pattern; bit r = row r lit (active-high)
write_error  output  1  one-cycle pulse: accepted write had an out-of-range column
commit  input  1  request to publish the back bank
commit_pending  output  1  commit requested, swap/copy not yet finished
scan_column  input  COLUMNS  one-hot column currently selected by the scanner
scan_advance  input  1  one-cycle strobe: scanner moves to next column this cycle
display_rows  output  ROWS  row pattern for scan_column from the front bank
frame_swapped  output  1  one-cycle pulse on the cycle the banks swap

Behaviour:
- Storage: two banks of COLUMNS x ROWS bits. A front-select flag picks the displayed bank; the other bank is the back bank.
- Reset (reset_n=0 at a clock edge):
  - Both banks cleared; front-select=0; FSM=IDLE.
  - write_ready=1, write_error=0, commit_pending=0, display_rows=0, frame_swapped=0.
  - Reset mid-PENDING or mid-COPY aborts the operation; no partial swap survives.
- Write handshake:
  - A transfer occurs when write_valid && write_ready at a clock edge.
  - write_column < COLUMNS: back[write_column] <= write_rows.
  - write_column >= COLUMNS: transfer completes, no storage change, write_error=1 next cycle for exactly one cycle.
  - write_ready=1 only in IDLE.
- FSM IDLE:
  - commit=1 -> PENDING; commit_pending=1 from the next cycle.
  - commit and a write in the same cycle: the write lands first, then PENDING.
- FSM PENDING:
  - write_ready=0; commit is ignored.
  - On scan_advance=1 while scan_column[COLUMNS-1]=1 (frame wrap): toggle front-select, pulse frame_swapped=1 for that one cycle, go to COPY with copy index 0.
- FSM COPY:
  - Copies the new front bank into the new back bank, one column per cycle, index 0..COLUMNS-1. This lets the producer make incremental edits.
  - Takes exactly COLUMNS cycles; after the last column go to IDLE.
  - commit_pending=0 and write_ready=1 on the first IDLE cycle.
  - commit is ignored during COPY.
- Display read path:
  - display_rows is registered: 1-cycle latency from scan_column to display_rows.
  - Value is front[i] for scan_column = one-hot bit i.
  - scan_column zero or multi-hot -> display_rows=0 (blank).
  - The swap takes effect on the read path from the cycle after frame_swapped: column 0 of the new frame shows the new image.
- Writes never touch the front bank, so the display never changes except at a swap.
- Commit latency is bounded: at most one full scan frame plus COLUMNS cycles.

Test Plan:
- Reset then scan all 5 one-hot columns -> display_rows=7'h00 each, write_ready=1, commit_pending=0.
- Write col0..col4 = 7'h01,7'h02,7'h04,7'h08,7'h10, commit, scan mid-frame (col 2) -> display stays 0 until the advance out of col4. Then frame_swapped pulses once, col0 reads 7'h01 a cycle later, col3 reads 7'h08, and write_ready returns after exactly 5 COPY cycles.
- After the above swap, write col2=7'h7F only and commit -> next frame shows 01,02,7F,08,10, proving the copy-back.
- Hold write_valid with col=3 during PENDING/COPY -> no transfer until IDLE, then back[3] updated; commit asserted during COPY is ignored (no second swap).
- write_column=5 and 7 -> write_error pulses 1 cycle each, no bank change; scan_column=5'b00011 or 5'b00000 -> display_rows=0.
- Assert reset_n=0 for one cycle during COPY -> all outputs at reset values next cycle; both banks read 0.
